// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter width.
package seq_divider_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must index 2*width quotient-bit steps
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(2 * width);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, conditionally
// subtract the divisor and emit one quotient bit.
module seq_divider_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_div_ext;
    logic           w_ge;

    assign w_shift   = {i_rem[WIDTH-1:0], i_msb};
    assign w_div_ext = {1'b0, i_div};
    // A bit shifted out of the top means r' already exceeds any divisor; the
    // modular subtraction below still yields the correct low bits.
    assign w_ge      = i_rem[WIDTH] | (w_shift >= w_div_ext);

    always_comb begin
        o_rem  = w_shift;
        o_qbit = 1'b0;
        if (w_ge) begin
            o_rem  = w_shift - w_div_ext;
            o_qbit = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per cycle, valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [2*WIDTH-1:0] io_in_lhs,
    input  logic [WIDTH-1:0]   io_in_rhs,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [2*WIDTH-1:0] io_out_quot,
    output logic [WIDTH-1:0]   io_out_rem,
    output logic               io_out_dbz
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_lhs;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH:0]     r_rem;
    logic [2*WIDTH-1:0] r_quot;
    logic               r_dbz;
    logic [2*WIDTH-1:0] r_out_quot;
    logic [WIDTH-1:0]   r_out_rem;
    logic               r_out_dbz;

    logic [WIDTH:0]     w_rem_nxt;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_quot_nxt;

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_lhs[2*WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    assign w_quot_nxt = {r_quot[2*WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_lhs      <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_out_quot <= '0;
            r_out_rem  <= '0;
            r_out_dbz  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_in_valid) begin
                        r_lhs   <= io_in_lhs;
                        r_div   <= io_in_rhs;
                        r_rem   <= '0;
                        r_quot  <= '0;
                        r_dbz   <= (io_in_rhs == '0);
                        r_cnt   <= '0;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    r_lhs  <= {r_lhs[2*WIDTH-2:0], 1'b0};
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_cnt  <= r_cnt + CNT_ONE;
                    // Last step: publish the result in the same edge
                    if (r_cnt == LAST_CNT) begin
                        r_out_quot <= w_quot_nxt;
                        r_out_rem  <= w_rem_nxt[WIDTH-1:0];
                        r_out_dbz  <= r_dbz;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    if (io_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_in_ready  = (r_state == StIdle);
    assign io_out_valid = (r_state == StDone);
    assign io_out_quot  = r_out_quot;
    assign io_out_rem   = r_out_rem;
    assign io_out_dbz   = r_out_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, known quotients, divide-by-zero,
// backpressure, mid-operation reset and a full operand sweep.
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           io_in_valid;
    logic           io_in_ready;
    logic [2*W-1:0] io_in_lhs;
    logic [W-1:0]   io_in_rhs;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [2*W-1:0] io_out_quot;
    logic [W-1:0]   io_out_rem;
    logic           io_out_dbz;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_lhs    (io_in_lhs),
        .io_in_rhs    (io_in_rhs),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_quot  (io_out_quot),
        .io_out_rem   (io_out_rem),
        .io_out_dbz   (io_out_dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accept edge
    task automatic start(input logic [2*W-1:0] lhs, input logic [W-1:0] rhs);
        int k;
        k = 0;
        while (!io_in_ready && k < 50) begin
            step();
            k++;
        end
        check("start_ready", {31'd0, io_in_ready}, 32'd1);
        io_in_lhs   = lhs;
        io_in_rhs   = rhs;
        io_in_valid = 1'b1;
        step();
        io_in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!io_out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2*W-1:0] lhs, input logic [W-1:0] rhs,
                       input logic [2*W-1:0] eq, input logic [W-1:0] er, input logic ed);
        int lat;
        start(lhs, rhs);
        wait_done(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_quot"}, {24'd0, io_out_quot}, {24'd0, eq});
        check({tag, "_rem"}, {28'd0, io_out_rem}, {28'd0, er});
        check({tag, "_dbz"}, {31'd0, io_out_dbz}, {31'd0, ed});
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, io_in_ready, io_out_valid}, 32'd2);
    endtask

    initial begin
        int lat;
        logic [2*W-1:0] eq;
        logic [W-1:0]   er;
        logic           ed;

        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_lhs    = '0;
        io_in_rhs    = '0;
        io_out_ready = 1'b0;
        #2;
        check("rst_valid", {31'd0, io_out_valid}, 32'd0);
        check("rst_data", {19'd0, io_out_quot, io_out_rem, io_out_dbz}, 32'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, io_in_ready}, 32'd1);

        run("t1", 8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0);
        run("t2a", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0);
        run("t2b", 8'h01, 4'hF, 8'h00, 4'h1, 1'b0);
        run("t3_dbz", 8'h5A, 4'h0, 8'hFF, 4'hA, 1'b1);

        // Reset at BUSY count=3
        start(8'h64, 4'h7);
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", {31'd0, io_out_valid}, 32'd0);
        check("t6_quot", {24'd0, io_out_quot}, 32'd0);
        check("t6_rem", {28'd0, io_out_rem}, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("t6_ready", {31'd0, io_in_ready}, 32'd1);
        run("t6_after", 8'hC8, 4'h9, 8'h16, 4'h2, 1'b0);

        // Backpressure in DONE
        start(8'h64, 4'h7);
        wait_done(lat);
        check("t4_lat", lat, 8);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_hold", {18'd0, io_in_ready, io_out_valid, io_out_quot, io_out_rem},
                  {18'd0, 1'b0, 1'b1, 8'h0E, 4'h2});
        end
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        check("t4_release", {30'd0, io_in_ready, io_out_valid}, 32'd2);

        // Sweep with io_in_valid held high and junk operands while not idle
        io_in_valid = 1'b1;
        for (int l = 0; l < 256; l++) begin
            for (int r = 0; r < 16; r++) begin
                io_in_lhs = 8'(l);
                io_in_rhs = 4'(r);
                step();
                lat = 0;
                while (!io_out_valid && lat < 40) begin
                    io_in_lhs = 8'($urandom);
                    io_in_rhs = 4'($urandom);
                    step();
                    lat++;
                end
                if (r == 0) begin
                    eq = 8'hFF;
                    er = 4'(l);
                    ed = 1'b1;
                end else begin
                    eq = 8'(l / r);
                    er = 4'(l % r);
                    ed = 1'b0;
                end
                check($sformatf("t5_sweep_%0h_%0h", l, r),
                      {lat[7:0], io_out_quot, 4'h0, io_out_rem, 7'd0, io_out_dbz},
                      {8'd8, eq, 4'h0, er, 7'd0, ed});
                io_out_ready = 1'b1;
                step();
                io_out_ready = 1'b0;
            end
        end
        io_in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
